vga_pixel_write_ctrl: RTL

Avalon-MM slave controller that accepts pixel write commands from the Nios CPU, buffers them in a small FIFO, and sequences them onto a valid/ready pixel port into the VGA frame-buffer writer. It produces the 4-bit `status` vector that is wired to the `in_port` of the pixel-status PIO. Software can therefore poll, or take edge interrupts on, idle, full, overflow and timeout conditions without reading this block.

---
 rtl/vga_pix_pkg.sv | 24 ++
 rtl/vga_pix_fifo.sv | 57 +++++
 rtl/vga_pixel_write_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pix_pkg.sv
// Shared definitions for the VGA pixel write controller: FSM states,
// register map and the bit positions of the STATUS and CTRL registers.
package vga_pix_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_COORD  = 2'd0;
    localparam logic [1:0] ADDR_PUSH   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int STAT_IDLE = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_TO   = 3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_AINC = 2;

endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous FIFO for pixel commands; registered pointers and count,
// combinational head data. A push is taken while full only with a same-cycle pop.
module vga_pix_fifo
    import vga_pix_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_dat,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];

    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

endmodule

// File: rtl/vga_pixel_write_ctrl.sv
// Avalon-MM slave that queues pixel writes and streams them to the frame-buffer
// writer over valid/ready, one pixel per cycle, with stall timeout and PIO status.
module vga_pixel_write_ctrl
    import vga_pix_pkg::*;
#(
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int COLOR_W    = 12,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic [3:0]         status
);
    localparam int DW = X_W + Y_W + COLOR_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic               r_en;
    logic               r_ainc;
    state_t             r_state;
    logic               r_valid;
    logic [X_W-1:0]     r_px;
    logic [Y_W-1:0]     r_py;
    logic [COLOR_W-1:0] r_pc;
    logic [TW-1:0]      r_stall;
    logic [3:0]         r_status;
    logic [31:0]        r_rdata;

    logic               w_wr;
    logic               w_coord_wr;
    logic               w_push;
    logic               w_ctrl_wr;
    logic               w_clear;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_cnt_nxt;
    logic [DW-1:0]      w_fifo_dat;
    logic               w_pop;
    logic               w_push_acc;
    logic               w_ovf_set;
    logic               w_send_done;
    logic               w_drop;
    state_t             w_state_nxt;
    logic               w_unused_wd;

    assign w_wr       = chipselect & ~write_n;
    assign w_coord_wr = w_wr & (address == ADDR_COORD);
    assign w_push     = w_wr & (address == ADDR_PUSH);
    assign w_ctrl_wr  = w_wr & (address == ADDR_CTRL);
    assign w_clear    = w_ctrl_wr & writedata[CTRL_CLR];
    assign w_unused_wd = ^writedata;

    assign w_send_done = (r_state == ST_SEND) & pix_ready;
    assign w_drop      = (r_state == ST_SEND) & ~pix_ready & (r_stall == TW'(TIMEOUT));
    assign w_pop       = r_en & ~w_empty & ((r_state == ST_IDLE) | w_send_done);
    assign w_push_acc  = w_push & (~w_full | w_pop);
    assign w_ovf_set   = w_push & w_full & ~w_pop;
    assign w_cnt_nxt   = w_count + CW'(w_push_acc) - CW'(w_pop);

    vga_pix_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_dat   ({r_x, r_y, writedata[COLOR_W-1:0]}),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_dat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_pop)
            w_state_nxt = ST_SEND;
        else if (w_send_done || w_drop)
            w_state_nxt = ST_IDLE;
    end

    // Auto-increment runs on every PUSH write, even one dropped by overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_en   <= 1'b0;
            r_ainc <= 1'b0;
        end else begin
            if (w_coord_wr) begin
                r_x <= writedata[X_W-1:0];
                r_y <= writedata[16 +: Y_W];
            end else if (w_push && r_ainc) begin
                if (r_x == X_W'(H_RES - 1)) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_W'(V_RES - 1)) ? '0 : r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
            if (w_ctrl_wr) begin
                r_en   <= writedata[CTRL_EN];
                r_ainc <= writedata[CTRL_AINC];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_pc    <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_valid              <= 1'b1;
                {r_px, r_py, r_pc}   <= w_fifo_dat;
                r_stall              <= '0;
            end else if (w_send_done || w_drop) begin
                r_valid <= 1'b0;
            end else if (r_state == ST_SEND) begin
                r_stall <= r_stall + TW'(1);
            end
        end
    end

    // Status is computed from next-cycle values so it tracks the FIFO count exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_status <= 4'b0001;
        end else begin
            r_status[STAT_IDLE] <= (w_cnt_nxt == '0) && (w_state_nxt == ST_IDLE);
            r_status[STAT_FULL] <= (w_cnt_nxt == CW'(FIFO_DEPTH));
            r_status[STAT_OVF]  <= w_ovf_set | (r_status[STAT_OVF] & ~w_clear);
            r_status[STAT_TO]   <= w_drop    | (r_status[STAT_TO]  & ~w_clear);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else begin
            case (address)
                ADDR_COORD: r_rdata <= 32'(r_x) | (32'(r_y) << 16);
                ADDR_PUSH:  r_rdata <= '0;
                ADDR_CTRL:  r_rdata <= {29'd0, r_ainc, 1'b0, r_en};
                default:    r_rdata <= {20'd0, 4'(w_count), 4'd0, r_status};
            endcase
        end
    end

    assign readdata  = r_rdata;
    assign pix_valid = r_valid;
    assign pix_x     = r_px;
    assign pix_y     = r_py;
    assign pix_color = r_pc;
    assign status    = r_status;

endmodule
